quad_decoder: RTL and testbench



---
 rtl/quad_decoder.sv | 169 ++++++++++++++++
 tb/tb_quad_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature phase decoder with sync, glitch filter, position/direction/error tracking; optional QDEC_VELOCITY_EN step-period output
module quad_decoder #(
    parameter int POS_W    = 16,
    parameter int FILT_LEN = 4,
    parameter int VEL_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phase_a,
    input  logic             phase_b,
    input  logic             enable,
    input  logic             clear_pos,
    input  logic             err_clear,
    output logic [POS_W-1:0] position,
    output logic             direction,
    output logic             step_pulse,
    output logic             error_flag
`ifdef QDEC_VELOCITY_EN
    ,
    output logic [VEL_W-1:0] velocity
`endif
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [3:0] FILT_TOP = 4'(FILT_LEN - 1);
    localparam logic [4:0] INIT_TOP = 5'(FILT_LEN + 2);

    // bit 1 = phase A, bit 0 = phase B throughout
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       filt_q, filt_d;
    logic [3:0]       fcnt_q [2];
    logic [3:0]       fcnt_d [2];
    logic [1:0]       prev_q, prev_d;
    logic [0:0]       state_q, state_d;
    logic [4:0]       icnt_q, icnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             pulse_q, pulse_d;
    logic             err_q, err_d;
    logic             run, changed, both, fwd, step, illegal;

    // filter and startup sequencing: INIT copies the synchronised pair straight through
    always_comb begin
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        state_d = state_q;
        icnt_d  = icnt_q;
        for (int i = 0; i < 2; i++) begin
            if (state_q == ST_INIT) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = 4'd0;
            end else if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_TOP) begin
                    filt_d[i] = sync2_q[i];
                    fcnt_d[i] = 4'd0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end else begin
                fcnt_d[i] = 4'd0;
            end
        end
        if (state_q == ST_INIT) begin
            if (icnt_q == INIT_TOP) begin
                state_d = ST_RUN;
            end else begin
                icnt_d = icnt_q + 5'd1;
            end
        end
    end

    // decode filtered pair against the previous pair; prev always tracks so re-enable is clean
    always_comb begin
        run     = (state_q == ST_RUN);
        changed = (filt_q != prev_q);
        both    = &(filt_q ^ prev_q);
        fwd     = ((prev_q == 2'b11) && (filt_q == 2'b01)) ||
                  ((prev_q == 2'b01) && (filt_q == 2'b00)) ||
                  ((prev_q == 2'b00) && (filt_q == 2'b10)) ||
                  ((prev_q == 2'b10) && (filt_q == 2'b11));
        illegal = run && both;
        step    = run && changed && !both && enable;
        prev_d  = filt_q;
        pos_d   = pos_q;
        if (step) begin
            pos_d = fwd ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end
        if (clear_pos) begin
            pos_d = '0;
        end
        dir_d   = step ? fwd : dir_q;
        pulse_d = step;
        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            filt_q    <= 2'b00;
            fcnt_q[0] <= 4'd0;
            fcnt_q[1] <= 4'd0;
            prev_q    <= 2'b00;
            state_q   <= ST_INIT;
            icnt_q    <= 5'd0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            pulse_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= {phase_a, phase_b};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
            prev_q    <= prev_d;
            state_q   <= state_d;
            icnt_q    <= icnt_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            pulse_q   <= pulse_d;
            err_q     <= err_d;
        end
    end

    assign position   = pos_q;
    assign direction  = dir_q;
    assign step_pulse = pulse_q;
    assign error_flag = err_q;

`ifdef QDEC_VELOCITY_EN
    logic [VEL_W-1:0] per_q, per_d;
    logic [VEL_W-1:0] vel_q, vel_d;

    // saturating period counter, captured (plus the step clock itself) on every counted step
    always_comb begin
        per_d = per_q;
        vel_d = vel_q;
        if (step) begin
            vel_d = (&per_q) ? per_q : (per_q + VEL_W'(1));
            per_d = '0;
        end else if (run && !(&per_q)) begin
            per_d = per_q + VEL_W'(1);
        end
    end

    // period registers
    always_ff @(posedge clk) begin
        if (rst) begin
            per_q <= '0;
            vel_q <= '0;
        end else begin
            per_q <= per_d;
            vel_q <= vel_d;
        end
    end

    assign velocity = vel_q;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - randomized self-checking bench for quad_decoder against an event-latency model
module tb_quad_decoder;

    localparam int FILT_LEN = 4;
    localparam int LAT      = FILT_LEN + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pa = 1'b1, pb = 1'b1;
    logic        enable = 1'b1, clear_pos = 1'b0, err_clear = 1'b0;
    logic [15:0] position;
    logic        direction, step_pulse, error_flag;
`ifdef QDEC_VELOCITY_EN
    logic [15:0] velocity;
`endif

    quad_decoder #(.POS_W(16), .FILT_LEN(FILT_LEN), .VEL_W(16)) dut (
        .clk(clk), .rst(rst), .phase_a(pa), .phase_b(pb), .enable(enable),
        .clear_pos(clear_pos), .err_clear(err_clear), .position(position),
        .direction(direction), .step_pulse(step_pulse), .error_flag(error_flag)
`ifdef QDEC_VELOCITY_EN
        , .velocity(velocity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int kind; } ev_t;  // kind 0 fwd, 1 rev, 2 illegal
    ev_t ev_q[$];

    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    int          pulse_cnt = 0, last_pulse_cyc = 0, chg_cyc = 0;
    bit          chk_on = 1'b0;
    logic [15:0] m_pos = 0;
    logic        m_dir = 0, m_pulse = 0, m_err = 0;
    int          m_vel = 0, vel_ref = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b11:   return 2'b01;
            2'b01:   return 2'b00;
            2'b00:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] s);
        case (s)
            2'b11:   return 2'b10;
            2'b10:   return 2'b00;
            2'b00:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // model: every settled raw transition lands LAT edges after the first edge that samples it
    always @(posedge clk) begin
        bit ill;
        cyc++;
        m_pulse = 1'b0;
        ill = 1'b0;
        if (rst) begin
            m_pos = 0; m_dir = 0; m_err = 0; m_vel = 0;
            vel_ref = cyc + LAT;
            ev_q.delete();
        end else begin
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                if (ev_q[0].kind == 2) ill = 1'b1;
                else if (enable) begin
                    m_pulse = 1'b1;
                    m_dir   = (ev_q[0].kind == 0);
                    m_pos   = (ev_q[0].kind == 0) ? m_pos + 16'd1 : m_pos - 16'd1;
                    m_vel   = (cyc - vel_ref > 65535) ? 65535 : cyc - vel_ref;
                    vel_ref = cyc;
                end
                void'(ev_q.pop_front());
            end
            if (clear_pos) m_pos = 0;
            if (ill) m_err = 1'b1;
            else if (err_clear) m_err = 1'b0;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("position", position, m_pos);
            chk("direction", direction, m_dir);
            chk("step_pulse", step_pulse, m_pulse);
            chk("error_flag", error_flag, m_err);
`ifdef QDEC_VELOCITY_EN
            chk("velocity", velocity, m_vel);
`endif
            if (step_pulse === 1'b1) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
            end
        end
    end

    // all drive tasks start and end on a negedge
    task automatic hold_cycles(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            clear_pos = rnd && ($urandom_range(0, 24) == 0);
            err_clear = rnd && ($urandom_range(0, 9) == 0);
        end
        clear_pos = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic drive_move(input int kind, input int hold, input bit rnd);
        logic [1:0] cur, nxt;
        ev_t e;
        cur = {pa, pb};
        nxt = (kind == 0) ? fwd_next(cur) : (kind == 1) ? rev_next(cur) : ~cur;
        {pa, pb} = nxt;
        chg_cyc = cyc;
        e.cyc = cyc + LAT;
        e.kind = kind;
        ev_q.push_back(e);
        hold_cycles(hold, rnd);
    endtask

    task automatic glitch(input int len, input bit on_b, input int hold);
        if (on_b) pb = ~pb; else pa = ~pa;
        repeat (len) @(negedge clk);
        if (on_b) pb = ~pb; else pa = ~pa;
        hold_cycles(hold, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;
        chk("reset_position", position, 16'd0);
        chk("reset_error", error_flag, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        hold_cycles(LAT + 3, 1'b0);
    endtask

    initial begin
        int p0;
        @(negedge clk);
        // phases 11 through reset and INIT
        do_reset();
        hold_cycles(20, 1'b0);
        chk("init_position", position, 16'd0);
        chk("init_error", error_flag, 1'b0);
        chk("init_pulses", pulse_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            drive_move(0, 10, 1'b0);
            chk("fwd_latency", last_pulse_cyc - chg_cyc, 7);
        end
        chk("fwd_position", position, 16'd8);
        chk("fwd_direction", direction, 1'b1);
        chk("fwd_pulses", pulse_cnt, 8);

        clear_pos = 1'b1;
        hold_cycles(2, 1'b0);
        for (int i = 0; i < 3; i++) drive_move(1, 10, 1'b0);
        chk("rev_position", position, 16'hFFFD);
        chk("rev_direction", direction, 1'b0);

        drive_move(2, 12, 1'b0);
        chk("ill_error", error_flag, 1'b1);
        chk("ill_position", position, 16'hFFFD);
        err_clear = 1'b1;
        hold_cycles(2, 1'b0);
        chk("errclr_error", error_flag, 1'b0);

        p0 = pulse_cnt;
        glitch(3, 1'b0, 12);
        enable = 1'b0;
        drive_move(0, 10, 1'b0);
        drive_move(0, 10, 1'b0);
        enable = 1'b1;
        hold_cycles(12, 1'b0);
        chk("glitch_position", position, 16'hFFFD);
        chk("glitch_pulses", pulse_cnt, p0);
        chk("glitch_error", error_flag, 1'b0);

        // clear_pos on the very edge the step lands
        p0 = pulse_cnt;
        drive_move(0, LAT - 1, 1'b0);
        clear_pos = 1'b1;
        @(negedge clk);
        clear_pos = 1'b0;
        chk("clrstep_pulse", step_pulse, 1'b1);
        hold_cycles(5, 1'b0);
        chk("clrstep_position", position, 16'd0);
        chk("clrstep_direction", direction, 1'b1);
        chk("clrstep_pulses", pulse_cnt, p0 + 1);

`ifdef QDEC_VELOCITY_EN
        for (int i = 0; i < 3; i++) drive_move(0, 50, 1'b0);
        chk("vel_50", velocity, 16'd50);
`endif

        for (int i = 0; i < 250; i++) begin
            int r, hold;
            r = $urandom_range(0, 99);
            hold = LAT + 1 + $urandom_range(0, 8);
            if (r < 35) drive_move(0, hold, 1'b1);
            else if (r < 70) drive_move(1, hold, 1'b1);
            else if (r < 78) drive_move(2, hold, 1'b1);
            else if (r < 90) glitch($urandom_range(1, FILT_LEN - 1), 1'($urandom_range(0, 1)), hold);
            else if (r < 97) begin
                enable = ~enable;
                drive_move($urandom_range(0, 1), hold, 1'b1);
            end else do_reset();
        end
        enable = 1'b1;
        hold_cycles(LAT + 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
